// File: rtl/serial_number_decoder.sv
// Snapshots a 6-char ASCII serial number and scans it one char per cycle to derive puzzle attribute flags.
// Optional format checking on sn_error is enabled by defining SN_VALIDATE_EN.
module serial_number_decoder #(
    parameter logic [2:0] IDLE       = 3'b000,
    parameter logic [2:0] ACTIVATING = 3'b001,
    parameter logic [2:0] ACTIVATED  = 3'b010
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  current_state,
    input  logic [47:0] serial_number,
    input  logic        sn_done,
    output logic        info_valid,
    output logic        has_vowel,
    output logic [3:0]  last_digit,
    output logic        last_digit_odd,
    output logic [5:0]  digit_sum,
    output logic [2:0]  letter_count,
    output logic [2:0]  digit_count,
    output logic        sn_error
);

    typedef enum logic [1:0] {S_IDLE, S_SCAN, S_HOLD} state_t;

    state_t      state_q;
    logic [47:0] shadow_q;
    logic [2:0]  idx_q;
    logic        acc_vowel_q;
    logic [5:0]  acc_sum_q;
    logic [2:0]  acc_letters_q;
    logic [2:0]  acc_digits_q;

    logic        valid_q, vowel_q, odd_q;
    logic [3:0]  last_q;
    logic [5:0]  sum_q;
    logic [2:0]  letters_q, digits_q;

    logic [7:0]  ch;
    logic        is_digit, is_letter, is_vowel;
    logic        vowel_d;
    logic [5:0]  sum_d;
    logic [2:0]  letters_d, digits_d;
    logic        go_idle, trigger;

    assign go_idle = (current_state == IDLE);
    assign trigger = sn_done && ((current_state == ACTIVATING) || (current_state == ACTIVATED));

    always_comb begin
        ch = 8'h00;
        case (idx_q)
            3'd0:    ch = shadow_q[47:40];
            3'd1:    ch = shadow_q[39:32];
            3'd2:    ch = shadow_q[31:24];
            3'd3:    ch = shadow_q[23:16];
            3'd4:    ch = shadow_q[15:8];
            default: ch = shadow_q[7:0];
        endcase
    end

    assign is_digit  = (ch >= 8'h30) && (ch <= 8'h39);
    assign is_letter = (ch >= 8'h41) && (ch <= 8'h5A);
    assign is_vowel  = (ch == "A") || (ch == "E") || (ch == "I") || (ch == "O") || (ch == "U");

    // ASCII digits carry their value in the low nibble
    assign vowel_d   = acc_vowel_q | is_vowel;
    assign sum_d     = acc_sum_q + (is_digit ? {2'b00, ch[3:0]} : 6'd0);
    assign letters_d = acc_letters_q + {2'b00, is_letter};
    assign digits_d  = acc_digits_q + {2'b00, is_digit};

`ifdef SN_VALIDATE_EN
    logic acc_bad_q, err_q, bad_d;
    assign bad_d    = acc_bad_q | ~(is_digit | is_letter) | (ch == "O") | (ch == "Y");
    assign sn_error = err_q;
`else
    assign sn_error = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= S_IDLE;
            shadow_q      <= '0;
            idx_q         <= '0;
            acc_vowel_q   <= 1'b0;
            acc_sum_q     <= '0;
            acc_letters_q <= '0;
            acc_digits_q  <= '0;
            valid_q       <= 1'b0;
            vowel_q       <= 1'b0;
            odd_q         <= 1'b0;
            last_q        <= '0;
            sum_q         <= '0;
            letters_q     <= '0;
            digits_q      <= '0;
`ifdef SN_VALIDATE_EN
            acc_bad_q     <= 1'b0;
            err_q         <= 1'b0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (trigger) begin
                        state_q       <= S_SCAN;
                        shadow_q      <= serial_number;
                        idx_q         <= '0;
                        acc_vowel_q   <= 1'b0;
                        acc_sum_q     <= '0;
                        acc_letters_q <= '0;
                        acc_digits_q  <= '0;
`ifdef SN_VALIDATE_EN
                        acc_bad_q     <= 1'b0;
`endif
                    end
                end
                S_SCAN: begin
                    if (go_idle) begin
                        state_q       <= S_IDLE;
                        idx_q         <= '0;
                        acc_vowel_q   <= 1'b0;
                        acc_sum_q     <= '0;
                        acc_letters_q <= '0;
                        acc_digits_q  <= '0;
`ifdef SN_VALIDATE_EN
                        acc_bad_q     <= 1'b0;
`endif
                    end else begin
                        acc_vowel_q   <= vowel_d;
                        acc_sum_q     <= sum_d;
                        acc_letters_q <= letters_d;
                        acc_digits_q  <= digits_d;
                        idx_q         <= idx_q + 3'd1;
`ifdef SN_VALIDATE_EN
                        acc_bad_q     <= bad_d;
`endif
                        // Results publish all at once so consumers never see a torn update
                        if (idx_q == 3'd5) begin
                            state_q   <= S_HOLD;
                            valid_q   <= 1'b1;
                            vowel_q   <= vowel_d;
                            sum_q     <= sum_d;
                            letters_q <= letters_d;
                            digits_q  <= digits_d;
                            last_q    <= is_digit ? ch[3:0] : 4'd0;
                            odd_q     <= is_digit & ch[0];
`ifdef SN_VALIDATE_EN
                            err_q     <= bad_d | ~is_digit | (letters_d == 3'd0);
`endif
                        end
                    end
                end
                S_HOLD: begin
                    if (go_idle) begin
                        state_q   <= S_IDLE;
                        valid_q   <= 1'b0;
                        vowel_q   <= 1'b0;
                        odd_q     <= 1'b0;
                        last_q    <= '0;
                        sum_q     <= '0;
                        letters_q <= '0;
                        digits_q  <= '0;
`ifdef SN_VALIDATE_EN
                        err_q     <= 1'b0;
`endif
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign info_valid     = valid_q;
    assign has_vowel      = vowel_q;
    assign last_digit     = last_q;
    assign last_digit_odd = odd_q;
    assign digit_sum      = sum_q;
    assign letter_count   = letters_q;
    assign digit_count    = digits_q;

endmodule

// File: tb/tb_serial_number_decoder.sv
// Directed self-checking bench for serial_number_decoder: decode vectors, snapshot, abort and async reset.
module tb_serial_number_decoder;

    localparam logic [2:0] IDLE       = 3'b000;
    localparam logic [2:0] ACTIVATING = 3'b001;
    localparam logic [2:0] ACTIVATED  = 3'b010;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [2:0]  current_state = IDLE;
    logic [47:0] serial_number = '0;
    logic        sn_done = 1'b0;
    logic        info_valid, has_vowel, last_digit_odd, sn_error;
    logic [3:0]  last_digit;
    logic [5:0]  digit_sum;
    logic [2:0]  letter_count, digit_count;

    int n_chk  = 0;
    int n_fail = 0;

`ifdef SN_VALIDATE_EN
    localparam logic ERR_NUMERIC = 1'b1;
`else
    localparam logic ERR_NUMERIC = 1'b0;
`endif

    serial_number_decoder #(.IDLE(IDLE), .ACTIVATING(ACTIVATING), .ACTIVATED(ACTIVATED)) dut (
        .clk(clk), .rst(rst), .current_state(current_state), .serial_number(serial_number),
        .sn_done(sn_done), .info_valid(info_valid), .has_vowel(has_vowel), .last_digit(last_digit),
        .last_digit_odd(last_digit_odd), .digit_sum(digit_sum), .letter_count(letter_count),
        .digit_count(digit_count), .sn_error(sn_error)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic v, input logic vw, input int sum,
                           input int lc, input int dc, input int ld, input logic err);
        chk({tag, ".valid"},  info_valid, v);
        chk({tag, ".vowel"},  has_vowel, vw);
        chk({tag, ".sum"},    digit_sum, sum);
        chk({tag, ".letters"}, letter_count, lc);
        chk({tag, ".digits"}, digit_count, dc);
        chk({tag, ".last"},   last_digit, ld);
        chk({tag, ".odd"},    last_digit_odd, ld[0]);
        chk({tag, ".err"},    sn_error, err);
    endtask

    task automatic edge1;
        @(posedge clk); #1;
    endtask

    // Snapshot at E0, confirm no early info_valid over E1..E5, return just after E6
    task automatic decode(input string tag, input logic [47:0] sn, input logic [2:0] cs);
        @(negedge clk);
        serial_number = sn; current_state = cs; sn_done = 1'b1;
        edge1;
        for (int k = 1; k <= 5; k++) begin
            edge1;
            chk({tag, ".early_valid"}, info_valid, 1'b0);
        end
        edge1;
    endtask

    task automatic go_idle(input string tag);
        @(negedge clk);
        current_state = IDLE; sn_done = 1'b0;
        edge1;
        chk_all({tag, ".idle"}, 1'b0, 1'b0, 0, 0, 0, 0, 1'b0);
    endtask

    initial begin
        #2 rst = 1'b0;
        #1 chk_all("reset", 1'b0, 1'b0, 0, 0, 0, 0, 1'b0);
        @(negedge clk) rst = 1'b1;

        decode("ab3d51", "AB3D51", ACTIVATING);
        chk_all("ab3d51", 1'b1, 1'b1, 9, 3, 3, 1, 1'b0);
        // Results stay frozen against input changes in hold
        @(negedge clk) serial_number = "7K9Q24";
        repeat (3) edge1;
        chk_all("hold", 1'b1, 1'b1, 9, 3, 3, 1, 1'b0);
        go_idle("ab3d51");

        decode("7k9q24", "7K9Q24", ACTIVATED);
        chk_all("7k9q24", 1'b1, 1'b0, 22, 2, 4, 4, 1'b0);
        go_idle("7k9q24");

        decode("123450", "123450", ACTIVATING);
        chk_all("123450", 1'b1, 1'b0, 15, 0, 6, 0, ERR_NUMERIC);
        go_idle("123450");

        // Input overwritten mid-scan; only the shadow copy counts
        @(negedge clk);
        serial_number = "AB3D51"; current_state = ACTIVATING; sn_done = 1'b1;
        edge1;                      // E0
        edge1;                      // E1
        serial_number = "ZZZZZZ";
        repeat (5) edge1;           // E2..E6
        chk_all("snapshot", 1'b1, 1'b1, 9, 3, 3, 1, 1'b0);
        go_idle("snapshot");

        // Abort: IDLE sampled at E3
        @(negedge clk);
        serial_number = "AB3D51"; current_state = ACTIVATING; sn_done = 1'b1;
        edge1;                      // E0
        edge1;                      // E1
        edge1;                      // E2
        current_state = IDLE;
        edge1;                      // E3
        chk_all("abort", 1'b0, 1'b0, 0, 0, 0, 0, 1'b0);
        repeat (6) edge1;
        chk("abort.stay_invalid", info_valid, 1'b0);
        decode("rearm", "7K9Q24", ACTIVATING);
        chk_all("rearm", 1'b1, 1'b0, 22, 2, 4, 4, 1'b0);

        // Asynchronous reset while holding results
        #2 rst = 1'b0;
        current_state = IDLE; sn_done = 1'b0;
        #1 chk_all("async_rst", 1'b0, 1'b0, 0, 0, 0, 0, 1'b0);
        @(negedge clk) rst = 1'b1;
        decode("post_rst", "AB3D51", ACTIVATING);
        chk_all("post_rst", 1'b1, 1'b1, 9, 3, 3, 1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
